// File: rtl/riscv_hazard_unit.sv
// Pipeline hazard controller: stage enables/clears, E-stage forwarding, load-use and dmem-wait FSM.
// Define RISCV_HAZARD_PERF_CNT_EN to add saturating stall/flush performance counters.
module riscv_hazard_unit #(
    parameter int LOAD_USE_STALL = 1,
    parameter int MEM_TIMEOUT    = 255
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [4:0]  i_hazard_d_rs1_addr,
    input  logic [4:0]  i_hazard_d_rs2_addr,
    input  logic [4:0]  i_hazard_e_rs1_addr,
    input  logic [4:0]  i_hazard_e_rs2_addr,
    input  logic [4:0]  i_hazard_e_rd_addr,
    input  logic        i_hazard_e_is_load,
    input  logic        i_hazard_e_pc_taken,
    input  logic [4:0]  i_hazard_m_rd_addr,
    input  logic        i_hazard_m_reg_wr_en,
    input  logic [4:0]  i_hazard_w_rd_addr,
    input  logic        i_hazard_w_reg_wr_en,
    input  logic        i_hazard_dmem_req,
    input  logic        i_hazard_dmem_ready,
    output logic [1:0]  o_hazard_fwd_a,
    output logic [1:0]  o_hazard_fwd_b,
    output logic        o_hazard_pc_en,
    output logic        o_hazard_fd_en,
    output logic        o_hazard_fd_clear,
    output logic        o_hazard_de_en,
    output logic        o_hazard_de_clear,
    output logic        o_hazard_em_en,
    output logic        o_hazard_mw_clear,
    output logic        o_hazard_mem_err,
`ifdef RISCV_HAZARD_PERF_CNT_EN
    output logic [31:0] o_hazard_stall_cnt,
    output logic [31:0] o_hazard_flush_cnt,
`endif
    output logic [1:0]  o_hazard_state
);

    // state      | meaning
    // S_RUN      | normal flow, single-bubble load-use handled here
    // S_LD_STALL | extra load-use bubbles, stall_rem left to insert
    // S_MEM_WAIT | dmem busy, whole front end frozen, wait_cnt counts busy cycles
    // S_MEM_ERR  | one-cycle timeout release, mem_err raised
    typedef enum logic [1:0] {
        S_RUN      = 2'b00,
        S_LD_STALL = 2'b01,
        S_MEM_WAIT = 2'b10,
        S_MEM_ERR  = 2'b11
    } state_t;

    localparam logic [31:0] TIMEOUT = 32'(MEM_TIMEOUT);

    state_t      state, state_nxt;
    logic [2:0]  stall_rem, stall_rem_nxt;
    logic [31:0] wait_cnt, wait_cnt_nxt, wait_now;
    logic        ret_ld, ret_ld_nxt;
    logic        busy, ldhz;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (i_hazard_m_reg_wr_en && i_hazard_m_rd_addr != 5'd0 && i_hazard_m_rd_addr == rs)
            return 2'b10;
        else if (i_hazard_w_reg_wr_en && i_hazard_w_rd_addr != 5'd0 && i_hazard_w_rd_addr == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign o_hazard_fwd_a = fwd_sel(i_hazard_e_rs1_addr);
    assign o_hazard_fwd_b = fwd_sel(i_hazard_e_rs2_addr);
    assign o_hazard_state = state;

    assign busy = i_hazard_dmem_req & ~i_hazard_dmem_ready;
    assign ldhz = i_hazard_e_is_load & (i_hazard_e_rd_addr != 5'd0) &
                  ((i_hazard_e_rd_addr == i_hazard_d_rs1_addr) |
                   (i_hazard_e_rd_addr == i_hazard_d_rs2_addr));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= S_RUN;
            stall_rem <= 3'd0;
            wait_cnt  <= 32'd0;
            ret_ld    <= 1'b0;
        end else begin
            state     <= state_nxt;
            stall_rem <= stall_rem_nxt;
            wait_cnt  <= wait_cnt_nxt;
            ret_ld    <= ret_ld_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        stall_rem_nxt     = stall_rem;
        wait_cnt_nxt      = wait_cnt;
        ret_ld_nxt        = ret_ld;
        o_hazard_pc_en    = 1'b1;
        o_hazard_fd_en    = 1'b1;
        o_hazard_fd_clear = 1'b0;
        o_hazard_de_en    = 1'b1;
        o_hazard_de_clear = 1'b0;
        o_hazard_em_en    = 1'b1;
        o_hazard_mw_clear = 1'b0;
        o_hazard_mem_err  = 1'b0;
        // busy cycles seen so far including this one
        wait_now = (state == S_MEM_WAIT) ? wait_cnt + 32'd1 : 32'd1;

        if (state == S_MEM_ERR) begin
            o_hazard_mem_err = 1'b1;
            state_nxt        = S_RUN;
            stall_rem_nxt    = 3'd0;
            wait_cnt_nxt     = 32'd0;
            ret_ld_nxt       = 1'b0;
        end else if (busy) begin
            o_hazard_pc_en    = 1'b0;
            o_hazard_fd_en    = 1'b0;
            o_hazard_de_en    = 1'b0;
            o_hazard_em_en    = 1'b0;
            o_hazard_mw_clear = 1'b1;
            if (state != S_MEM_WAIT)
                ret_ld_nxt = (state == S_LD_STALL) && (stall_rem != 3'd0);
            if (TIMEOUT != 32'd0 && wait_now >= TIMEOUT) begin
                state_nxt = S_MEM_ERR;
            end else begin
                state_nxt    = S_MEM_WAIT;
                wait_cnt_nxt = wait_now;
            end
        end else if (i_hazard_e_pc_taken) begin
            o_hazard_fd_clear = 1'b1;
            o_hazard_de_clear = 1'b1;
            state_nxt         = S_RUN;
            stall_rem_nxt     = 3'd0;
            wait_cnt_nxt      = 32'd0;
            ret_ld_nxt        = 1'b0;
        end else if (state == S_MEM_WAIT) begin
            state_nxt    = ret_ld ? S_LD_STALL : S_RUN;
            wait_cnt_nxt = 32'd0;
            ret_ld_nxt   = 1'b0;
        end else if (state == S_LD_STALL || ldhz) begin
            o_hazard_pc_en    = 1'b0;
            o_hazard_fd_en    = 1'b0;
            o_hazard_de_clear = 1'b1;
            if (state == S_LD_STALL) begin
                stall_rem_nxt = stall_rem - 3'd1;
                if (stall_rem == 3'd1)
                    state_nxt = S_RUN;
            end else if (LOAD_USE_STALL > 1) begin
                state_nxt     = S_LD_STALL;
                stall_rem_nxt = 3'(LOAD_USE_STALL - 1);
            end
        end
    end

`ifdef RISCV_HAZARD_PERF_CNT_EN
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_hazard_stall_cnt <= 32'd0;
            o_hazard_flush_cnt <= 32'd0;
        end else begin
            if (!o_hazard_pc_en && o_hazard_stall_cnt != 32'hFFFF_FFFF)
                o_hazard_stall_cnt <= o_hazard_stall_cnt + 32'd1;
            if (o_hazard_fd_clear && o_hazard_flush_cnt != 32'hFFFF_FFFF)
                o_hazard_flush_cnt <= o_hazard_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_hazard_unit.sv
// Scoreboard bench for riscv_hazard_unit: two instances (default params, and LOAD_USE_STALL=3/MEM_TIMEOUT=4).
module tb_riscv_hazard_unit;

    logic       clk = 1'b0;
    logic       rstn;
    logic [4:0] d_rs1, d_rs2, e_rs1, e_rs2, e_rd, m_rd, w_rd;
    logic       e_ld, taken, m_wr, w_wr, dreq, drdy;

    logic [1:0] fa_a, fb_a, st_a, fa_b, fb_b, st_b;
    logic pc_a, fde_a, fdc_a, dee_a, dec_a, em_a, mw_a, err_a;
    logic pc_b, fde_b, fdc_b, dee_b, dec_b, em_b, mw_b, err_b;
`ifdef RISCV_HAZARD_PERF_CNT_EN
    logic [31:0] sc_a, fc_a, sc_b, fc_b;
`endif

    always #5 clk = ~clk;

    riscv_hazard_unit #(.LOAD_USE_STALL(1), .MEM_TIMEOUT(255)) dut_a (
        .i_clk(clk), .i_rstn(rstn),
        .i_hazard_d_rs1_addr(d_rs1), .i_hazard_d_rs2_addr(d_rs2),
        .i_hazard_e_rs1_addr(e_rs1), .i_hazard_e_rs2_addr(e_rs2),
        .i_hazard_e_rd_addr(e_rd), .i_hazard_e_is_load(e_ld), .i_hazard_e_pc_taken(taken),
        .i_hazard_m_rd_addr(m_rd), .i_hazard_m_reg_wr_en(m_wr),
        .i_hazard_w_rd_addr(w_rd), .i_hazard_w_reg_wr_en(w_wr),
        .i_hazard_dmem_req(dreq), .i_hazard_dmem_ready(drdy),
        .o_hazard_fwd_a(fa_a), .o_hazard_fwd_b(fb_a), .o_hazard_pc_en(pc_a),
        .o_hazard_fd_en(fde_a), .o_hazard_fd_clear(fdc_a),
        .o_hazard_de_en(dee_a), .o_hazard_de_clear(dec_a),
        .o_hazard_em_en(em_a), .o_hazard_mw_clear(mw_a), .o_hazard_mem_err(err_a),
`ifdef RISCV_HAZARD_PERF_CNT_EN
        .o_hazard_stall_cnt(sc_a), .o_hazard_flush_cnt(fc_a),
`endif
        .o_hazard_state(st_a));

    riscv_hazard_unit #(.LOAD_USE_STALL(3), .MEM_TIMEOUT(4)) dut_b (
        .i_clk(clk), .i_rstn(rstn),
        .i_hazard_d_rs1_addr(d_rs1), .i_hazard_d_rs2_addr(d_rs2),
        .i_hazard_e_rs1_addr(e_rs1), .i_hazard_e_rs2_addr(e_rs2),
        .i_hazard_e_rd_addr(e_rd), .i_hazard_e_is_load(e_ld), .i_hazard_e_pc_taken(taken),
        .i_hazard_m_rd_addr(m_rd), .i_hazard_m_reg_wr_en(m_wr),
        .i_hazard_w_rd_addr(w_rd), .i_hazard_w_reg_wr_en(w_wr),
        .i_hazard_dmem_req(dreq), .i_hazard_dmem_ready(drdy),
        .o_hazard_fwd_a(fa_b), .o_hazard_fwd_b(fb_b), .o_hazard_pc_en(pc_b),
        .o_hazard_fd_en(fde_b), .o_hazard_fd_clear(fdc_b),
        .o_hazard_de_en(dee_b), .o_hazard_de_clear(dec_b),
        .o_hazard_em_en(em_b), .o_hazard_mw_clear(mw_b), .o_hazard_mem_err(err_b),
`ifdef RISCV_HAZARD_PERF_CNT_EN
        .o_hazard_stall_cnt(sc_b), .o_hazard_flush_cnt(fc_b),
`endif
        .o_hazard_state(st_b));

    // {fwd_a, fwd_b, pc_en, fd_en, fd_clear, de_en, de_clear, em_en, mw_clear, mem_err, state}
    typedef struct {
        string      name;
        int         sel;
        logic [13:0] exp;
    } chk_t;

    chk_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic logic [13:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic pc, input logic fde, input logic fdc,
                                       input logic dee, input logic dec, input logic em,
                                       input logic mw, input logic err, input logic [1:0] st);
        return {fa, fb, pc, fde, fdc, dee, dec, em, mw, err, st};
    endfunction

    function automatic logic [13:0] e_def(input logic [1:0] st);
        return mk(2'b00, 2'b00, 1, 1, 0, 1, 0, 1, 0, 0, st);
    endfunction
    function automatic logic [13:0] e_bub(input logic [1:0] st);
        return mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 0, 0, st);
    endfunction
    function automatic logic [13:0] e_bsy(input logic [1:0] st);
        return mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, st);
    endfunction
    function automatic logic [13:0] e_tkn(input logic [1:0] st);
        return mk(2'b00, 2'b00, 1, 1, 1, 1, 1, 1, 0, 0, st);
    endfunction
    function automatic logic [13:0] e_fwd(input logic [1:0] fa, input logic [1:0] fb);
        return mk(fa, fb, 1, 1, 0, 1, 0, 1, 0, 0, 2'b00);
    endfunction

    // monitor: one expectation per cycle, compared mid-cycle
    always @(negedge clk) begin
        chk_t        c;
        logic [13:0] act;
        if (sb_q.size() > 0) begin
            c = sb_q.pop_front();
            if (c.sel == 0)
                act = {fa_a, fb_a, pc_a, fde_a, fdc_a, dee_a, dec_a, em_a, mw_a, err_a, st_a};
            else
                act = {fa_b, fb_b, pc_b, fde_b, fdc_b, dee_b, dec_b, em_b, mw_b, err_b, st_b};
            n_checks++;
            if (act !== c.exp) begin
                n_err++;
                $display("FAIL %s (dut_%0s): got %b expected %b", c.name,
                         (c.sel == 0) ? "a" : "b", act, c.exp);
            end
        end
    end

    task automatic cyc(input string nm, input int sel, input logic [13:0] exp);
        chk_t c;
        c.name = nm;
        c.sel  = sel;
        c.exp  = exp;
        sb_q.push_back(c);
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        d_rs1 = 0; d_rs2 = 0; e_rs1 = 0; e_rs2 = 0; e_rd = 0; m_rd = 0; w_rd = 0;
        e_ld = 0; taken = 0; m_wr = 0; w_wr = 0; dreq = 0; drdy = 0;
    endtask

    task automatic rst_pulse();
        rstn = 1'b0;
        clr_in();
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic set_ldhz();
        e_ld = 1; e_rd = 5'd5; d_rs1 = 5'd5;
    endtask

    initial begin
        rstn = 1'b0;
        clr_in();
        @(posedge clk); #1;
        cyc("reset_a", 0, e_def(2'b00));
        cyc("reset_b", 1, e_def(2'b00));
        rstn = 1'b1;
        @(posedge clk); #1;

        // load-use, single bubble
        set_ldhz();
        cyc("ldhz1_bubble", 0, e_bub(2'b00));
        clr_in();
        cyc("ldhz1_after", 0, e_def(2'b00));
        e_ld = 1; e_rd = 0; d_rs1 = 0; d_rs2 = 0;
        cyc("ldhz_x0_none", 0, e_def(2'b00));
        e_ld = 1; e_rd = 5'd9; d_rs1 = 5'd1; d_rs2 = 5'd9;
        cyc("ldhz_rs2", 0, e_bub(2'b00));
        clr_in();

        // forwarding
        m_rd = 3; m_wr = 1; w_rd = 3; w_wr = 1; e_rs1 = 3; e_rs2 = 0;
        cyc("fwd_m_over_w", 0, e_fwd(2'b10, 2'b00));
        m_rd = 0; m_wr = 1; w_rd = 0; w_wr = 1; e_rs1 = 0; e_rs2 = 0;
        cyc("fwd_x0", 0, e_fwd(2'b00, 2'b00));
        m_rd = 4; m_wr = 0; w_rd = 4; w_wr = 1; e_rs1 = 9; e_rs2 = 4;
        cyc("fwd_w_only", 0, e_fwd(2'b00, 2'b01));
        m_rd = 6; m_wr = 1; w_rd = 7; w_wr = 1; e_rs1 = 7; e_rs2 = 6;
        cyc("fwd_split", 0, e_fwd(2'b01, 2'b10));
        clr_in();

        // dmem wait, default timeout
        rst_pulse();
        dreq = 1; drdy = 0;
        cyc("wait_c1", 0, e_bsy(2'b00));
        cyc("wait_c2", 0, e_bsy(2'b10));
        cyc("wait_c3", 0, e_bsy(2'b10));
        drdy = 1;
        cyc("wait_ready", 0, e_def(2'b10));
        clr_in();
        cyc("wait_after", 0, e_def(2'b00));

        // taken overrides load-use
        rst_pulse();
        set_ldhz(); taken = 1;
        cyc("taken_ldhz", 1, e_tkn(2'b00));
        clr_in();
        cyc("taken_after", 1, e_def(2'b00));
        set_ldhz();
        cyc("ld3_b1", 1, e_bub(2'b00));
        taken = 1;
        cyc("taken_in_ldstall", 1, e_tkn(2'b01));
        clr_in();
        cyc("taken_ldstall_after", 1, e_def(2'b00));

        // timeout = 4
        rst_pulse();
        dreq = 1; drdy = 0;
        cyc("to_c1", 1, e_bsy(2'b00));
        cyc("to_c2", 1, e_bsy(2'b10));
        cyc("to_c3", 1, e_bsy(2'b10));
        cyc("to_c4", 1, e_bsy(2'b10));
        cyc("to_err", 1, mk(2'b00, 2'b00, 1, 1, 0, 1, 0, 1, 0, 1, 2'b11));
        cyc("to_back_run", 1, e_bsy(2'b00));
        clr_in();

        // three bubbles with a dmem wait on the second
        rst_pulse();
        set_ldhz();
        cyc("ld3_bub1", 1, e_bub(2'b00));
        dreq = 1; drdy = 0;
        cyc("ld3_busy1", 1, e_bsy(2'b01));
        cyc("ld3_busy2", 1, e_bsy(2'b10));
        drdy = 1;
        cyc("ld3_ready", 1, e_def(2'b10));
        dreq = 0; drdy = 0;
        cyc("ld3_bub2", 1, e_bub(2'b01));
        cyc("ld3_bub3", 1, e_bub(2'b01));
        clr_in();
        cyc("ld3_done", 1, e_def(2'b00));

        // async reset while in LD_STALL
        set_ldhz();
        cyc("rst_bub1", 1, e_bub(2'b00));
        cyc("rst_bub2", 1, e_bub(2'b01));
        rstn = 1'b0;
        clr_in();
        cyc("rst_async", 1, e_def(2'b00));
        rstn = 1'b1;
        cyc("rst_no_pending", 1, e_def(2'b00));

        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: bench did not finish in time, expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
